// File: rtl/credit_pkg.sv
// Shared credit-link definitions: counter width helper and the error status encoding
// used by both the transmit and (future) receive ends of a credit-flow link.
package credit_pkg;

  typedef enum logic {
    CREDIT_OK  = 1'b0,
    CREDIT_OVF = 1'b1
  } credit_err_e;

  function automatic int unsigned credit_cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Saturating credit counter with sticky overflow status; a return arriving while
// already full is an overflow, and a simultaneous consume makes it legal.
module credit_counter
  import credit_pkg::*;
#(
  parameter  int unsigned NumCredits = 4,
  localparam int unsigned CntW       = credit_cnt_width(NumCredits)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            consume_i,
  input  logic            return_i,
  input  logic            err_clr_i,
  output logic [CntW-1:0] count_o,
  output logic            avail_o,
  output logic            ovf_o
);

  localparam logic [CntW-1:0] Full = CntW'(NumCredits);

  logic [CntW-1:0] count_q, count_d;
  logic            ovf;
  credit_err_e     err_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    count_d = count_q;
    ovf     = 1'b0;
    unique case ({consume_i, return_i})
      2'b10: count_d = count_q - 1'b1;
      2'b01: begin
        if (count_q == Full) ovf = 1'b1;
        else                 count_d = count_q + 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= Full;
      err_q   <= CREDIT_OK;
    end else begin
      count_q <= count_d;
      // A new overflow outranks a clear in the same cycle.
      if (ovf)            err_q <= CREDIT_OVF;
      else if (err_clr_i) err_q <= CREDIT_OK;
    end
  end

  assign count_o = count_q;
  assign avail_o = (count_q != '0);
  assign ovf_o   = (err_q == CREDIT_OVF);

endmodule

// File: rtl/credit_stream_tx.sv
// Transmit end of a credit-flow link: valid/ready in, valid-only out, one credit
// consumed per beat and restored by each returned credit pulse.
module credit_stream_tx
  import credit_pkg::*;
#(
  parameter  type         T          = logic,
  parameter  int unsigned NumCredits = 4,
  parameter  bit          RegOut     = 1'b1,
  localparam int unsigned CntW       = credit_cnt_width(NumCredits)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            vld_i,
  output logic            rdy_o,
  input  T                data_i,
  output logic            vld_o,
  output T                data_o,
  input  logic            credit_i,
  input  logic            err_clr_i,
  output logic [CntW-1:0] credits_o,
  output logic            err_o
);

  logic avail;
  logic send;

  credit_counter #(
    .NumCredits(NumCredits)
  ) u_counter (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .consume_i(send),
    .return_i (credit_i),
    .err_clr_i(err_clr_i),
    .count_o  (credits_o),
    .avail_o  (avail),
    .ovf_o    (err_o)
  );

  // Ready comes only from registered credit state; holding it low in reset keeps
  // the pass-through variant from emitting a beat while the link is being reset.
  assign rdy_o = avail && rst_ni;
  assign send  = vld_i && rdy_o;

  if (RegOut) begin : g_reg_out
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_o  <= 1'b0;
        data_o <= '0;
      end else begin
        vld_o <= send;
        if (send) data_o <= data_i;
      end
    end
  end else begin : g_comb_out
    assign vld_o  = send;
    assign data_o = data_i;
  end

  a_hold_until_accepted: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (vld_i && !rdy_o) |=> (vld_i && $stable(data_i))
  );

  a_credit_bound: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    credits_o <= CntW'(NumCredits)
  );

endmodule
